ili_spi_byte_tx: RTL and testbench
==================================

Name: ili_spi_byte_tx

Overview:
- SPI byte transmitter for the ILI9341 link; the target end of the command/data handshake driven by the init and pixel sequencers.
- Accepts one 8-bit word plus D/C flag per send request.
- Serializes the word onto the display SPI bus: mode 0, MSB first, CS active-low.
- Returns a one-cycle done pulse that the sequencers consume as their "command sent" input.

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period; legal range 1..255.
- DATA_W, 8, bits per transfer; fixed at 8 for ILI9341, kept parameterised for the bench.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- i_send  input  1  transfer request; sampled only when accepted (see Behaviour).
- i_data  input  DATA_W  word to transmit; captured at accept.
- i_dc  input  1  D/C level for this word (0 = command, 1 = data); captured at accept.
- o_busy  output  1  high whenever state is not IDLE.
- o_sent  output  1  one-cycle pulse at end of transfer.
- o_sclk  output  1  SPI clock; idles low.
- o_mosi  output  1  SPI data out.
- o_dc  output  1  display D/C line.
- o_cs  output  1  display chip select, active-low.

Behaviour:
- Reset (async, immediate, also mid-transfer):
  - state = IDLE.
  - o_busy = 0, o_sent = 0, o_sclk = 0, o_mosi = 0, o_dc = 1, o_cs = 1.
  - All counters cleared; shift register cleared.
- Registered outputs only; no combinational path from any input to any output.
- Internal half-period tick: a divider counter counts CLK_DIV-1 down to 0 while state is not IDLE. A tick is generated at 0 and the counter reloads. The counter is held at CLK_DIV-1 in IDLE.
- IDLE:
  - o_cs = 1, o_sclk = 0; o_dc holds its last value.
  - On a clk edge with i_send = 1: latch i_data into the shift register, latch i_dc to o_dc, drive o_cs = 0, go to SETUP.
- SETUP:
  - One half-period (CLK_DIV cycles) of CS-to-SCLK setup.
  - o_mosi = shreg MSB.
  - On tick go to SHIFT with bit counter = DATA_W-1 and phase = low.
- SHIFT:
  - On each tick o_sclk toggles.
  - Low-to-high: no data change (display samples on the rising edge).
  - High-to-low with bit counter > 0: shift left, o_mosi = new MSB, decrement bit counter.
  - High-to-low with bit counter = 0: go to HOLD with o_sclk = 0.
  - SHIFT therefore lasts 2*DATA_W half-periods.
- HOLD:
  - One half-period of SCLK-low hold with o_cs still 0.
  - o_sent = 1 in the last HOLD cycle (the tick cycle); next state is IDLE, where o_cs returns to 1.
- Latency: o_sent is asserted exactly (2*DATA_W+2)*CLK_DIV cycles after the accepting edge. That is 72 cycles for the defaults.
- Busy requests: i_send while o_busy = 1 is ignored (no queueing, no error). The sender must wait for o_sent.
- Captured values: i_data and i_dc changes after accept have no effect on the current transfer.
- Back-to-back (macro off): i_send in the cycle after o_sent is accepted from IDLE. o_cs is high for exactly 1 cycle between bytes.
- CLK_DIV = 1: a tick occurs every cycle; the sequence and latency formula are unchanged.

Optional Feature:
- Macro: ILI_SPI_BURST_EN.
- Defined:
  - If i_send = 1 in the o_sent cycle, the new word and D/C are latched in that cycle and the FSM goes directly to SHIFT (skipping IDLE and SETUP).
  - o_cs stays 0 across bytes; o_busy stays 1.
  - o_sent is still pulsed once per byte.
  - A burst byte's latency is (2*DATA_W+1)*CLK_DIV.
- Undefined: i_send during the o_sent cycle is ignored, exactly as in the base behaviour.

Decomposition:
- Shared package ili_pkg:
  - FSM enum (IDLE, SETUP, SHIFT, HOLD).
  - Constants LOW/HIGH, ON/OFF, NO_DATA, and ILI_WORD_W = 8. The sequencers reuse the same package.
- One sub-module: ili_spi_tick_gen (enable in, CLK_DIV param, tick out). It holds the divider counter and reload logic.

Test Plan:
- Reset, then i_send = 1 for one cycle with i_data = 0xA5, i_dc = 0:
  - o_cs falls the next cycle.
  - 8 rising SCLK edges sample MOSI = 1,0,1,0,0,1,0,1.
  - o_dc = 0 throughout.
  - o_sent pulses once at +72 cycles; o_cs rises 1 cycle later.
- CLK_DIV = 1, i_data = 0x3C, i_dc = 1: o_sent at +18 cycles; bits sampled 0,0,1,1,1,1,0,0; SCLK period 2 cycles.
- Hold i_send = 1 continuously with i_data toggling every cycle: only the word present at the accept edge is transmitted. The next transfer starts 1 cycle after o_sent, with a 1-cycle o_cs high gap (macro off).
- Assert rst low during bit 4 of a transfer: all outputs at reset values asynchronously. After release, the FSM is in IDLE and o_sent is never pulsed for the aborted byte.
- ILI_SPI_BURST_EN defined, i_send held in each o_sent cycle for words 0x2A, 0x00, 0xEF:
  - o_cs stays low across all three bytes.
  - 3 o_sent pulses at +72, +140, +208 cycles.
- i_send pulsed mid-transfer (cycle 30 of 72): ignored; exactly one o_sent; no second transfer starts.

Source files
------------

// File: rtl/ili_pkg.sv
// Shared ILI9341 link package: FSM encoding and link-wide constants.
// Imported by the SPI byte transmitter and the init/pixel sequencers.
package ili_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } ili_state_e;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;
  localparam logic OFF  = 1'b0;
  localparam logic ON   = 1'b1;

  localparam int ILI_WORD_W = 8;

  localparam logic [ILI_WORD_W-1:0] NO_DATA = '0;

endpackage

// File: rtl/ili_spi_byte_tx_if.sv
// Send/done handshake plus display SPI pins of the byte transmitter.
// master: sequencer side (drives i_*); slave: transmitter (drives o_*).
interface ili_spi_byte_tx_if
  import ili_pkg::*;
#(
  parameter int DATA_W = ILI_WORD_W
);

  logic              i_send;
  logic [DATA_W-1:0] i_data;
  logic              i_dc;
  logic              o_busy;
  logic              o_sent;
  logic              o_sclk;
  logic              o_mosi;
  logic              o_dc;
  logic              o_cs;

  modport master (
    output i_send, i_data, i_dc,
    input  o_busy, o_sent, o_sclk,
    input  o_mosi, o_dc, o_cs
  );

  modport slave (
    input  i_send, i_data, i_dc,
    output o_busy, o_sent, o_sclk,
    output o_mosi, o_dc, o_cs
  );

endinterface

// File: rtl/ili_spi_tick_gen.sv
// SCLK half-period tick: counts CLK_DIV-1 down to 0 while en is high.
// Ports: clk, rst (async low), en, tick (now), tick_next (next cycle).
module ili_spi_tick_gen
  import ili_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic tick_next
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  assign tick = en && (cnt == 8'd0);

  always_comb begin
    cnt_nxt = RELOAD;
    if (en && cnt != 8'd0)
      cnt_nxt = cnt - 8'd1;
  end

  // Assumes en stays high; only consulted mid-transfer.
  assign tick_next = (cnt_nxt == 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= RELOAD;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/ili_spi_byte_tx.sv
// ILI9341 SPI byte transmitter: mode 0, MSB first, CS low, done pulse.
// Ports: clk, rst (async low), bus (slave). Option: ILI_SPI_BURST_EN.
module ili_spi_byte_tx
  import ili_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = ILI_WORD_W
) (
  input  logic               clk,
  input  logic               rst,
  ili_spi_byte_tx_if.slave   bus
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  ili_state_e        state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              tick;
  logic              tick_next;

  ili_spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (state != IDLE),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= NO_DATA;
      bit_cnt    <= '0;
      bus.o_busy <= OFF;
      bus.o_sent <= OFF;
      bus.o_sclk <= LOW;
      bus.o_mosi <= LOW;
      bus.o_dc   <= HIGH;
      bus.o_cs   <= HIGH;
    end else begin
      bus.o_sent <= OFF;
      unique case (state)
        IDLE: begin
          bus.o_cs   <= HIGH;
          bus.o_sclk <= LOW;
          if (bus.i_send) begin
            shreg      <= bus.i_data;
            bus.o_mosi <= bus.i_data[DATA_W-1];
            bus.o_dc   <= bus.i_dc;
            bus.o_cs   <= LOW;
            bus.o_busy <= ON;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            bit_cnt <= BW'(DATA_W - 1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!bus.o_sclk) begin
              bus.o_sclk <= HIGH;
            end else begin
              bus.o_sclk <= LOW;
              if (bit_cnt != '0) begin
                shreg      <= {shreg[DATA_W-2:0], 1'b0};
                bus.o_mosi <= shreg[DATA_W-2];
                bit_cnt    <= bit_cnt - 1'b1;
              end else begin
                state      <= HOLD;
                // CLK_DIV = 1: HOLD is a single tick cycle
                bus.o_sent <= tick_next;
              end
            end
          end
        end
        HOLD: begin
          if (!tick) begin
            // raise o_sent so it lands on the tick cycle
            bus.o_sent <= tick_next;
          end else begin
`ifdef ILI_SPI_BURST_EN
            if (bus.i_send) begin
              shreg      <= bus.i_data;
              bus.o_mosi <= bus.i_data[DATA_W-1];
              bus.o_dc   <= bus.i_dc;
              bit_cnt    <= BW'(DATA_W - 1);
              state      <= SHIFT;
            end else begin
              bus.o_cs   <= HIGH;
              bus.o_busy <= OFF;
              state      <= IDLE;
            end
`else
            bus.o_cs   <= HIGH;
            bus.o_busy <= OFF;
            state      <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ili_spi_byte_tx.sv
// Scoreboard bench for ili_spi_byte_tx (CLK_DIV 4 and CLK_DIV 1 instances).
// o_sent occupies the cycle that closes at clock edge accept+latency.
module tb_ili_spi_byte_tx;
  import ili_pkg::*;

  typedef struct packed {
    logic [7:0]  data;
    logic        dc;
    logic [31:0] end_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];

  ili_spi_byte_tx_if #(.DATA_W(8)) b0 ();
  ili_spi_byte_tx_if #(.DATA_W(8)) b1 ();

  ili_spi_byte_tx #(.CLK_DIV(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  ili_spi_byte_tx #(.CLK_DIV(1), .DATA_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  logic [1:0] w_sclk, w_mosi, w_sent, w_cs, w_dc, w_busy;
  assign w_sclk = {b1.o_sclk, b0.o_sclk};
  assign w_mosi = {b1.o_mosi, b0.o_mosi};
  assign w_sent = {b1.o_sent, b0.o_sent};
  assign w_cs   = {b1.o_cs,   b0.o_cs};
  assign w_dc   = {b1.o_dc,   b0.o_dc};
  assign w_busy = {b1.o_busy, b0.o_busy};

  logic [7:0] m_bits  [2];
  int         m_nbits [2];
  logic       m_prev  [2];
  logic       m_dcbad [2];
  logic       m_gap   [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int   qs;
      exp_t e;
      qs = (d == 0) ? q0.size() : q1.size();
      if (!rst) begin
        m_bits[d]  = '0;
        m_nbits[d] = 0;
        m_prev[d]  = 1'b0;
        m_dcbad[d] = 1'b0;
        m_gap[d]   = 1'b0;
      end else begin
`ifndef ILI_SPI_BURST_EN
        if (m_gap[d]) chk($sformatf("cs_gap%0d", d), 32'(w_cs[d]), 1);
`endif
        m_gap[d] = 1'b0;
        if (w_sclk[d] && !m_prev[d]) begin
          m_bits[d] = {m_bits[d][6:0], w_mosi[d]};
          m_nbits[d]++;
        end
        m_prev[d] = w_sclk[d];
        if (qs > 0 && !w_cs[d]) begin
          e = (d == 0) ? q0[0] : q1[0];
          if (w_dc[d] !== e.dc) m_dcbad[d] = 1'b1;
        end
        if (w_sent[d]) begin
          if (qs == 0) begin
            chk($sformatf("unexpected_sent%0d", d), 1, 0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("bits%0d", d), 32'(m_bits[d]), 32'(e.data));
            chk($sformatf("nrise%0d", d), 32'(m_nbits[d]), 8);
            chk($sformatf("dc%0d", d), 32'(m_dcbad[d]), 0);
            chk($sformatf("lat%0d", d), 32'(cyc + 1), e.end_cyc);
          end
          m_bits[d]  = '0;
          m_nbits[d] = 0;
          m_dcbad[d] = 1'b0;
          m_gap[d]   = 1'b1;
        end
      end
    end
  end

  task automatic drive(input int d, input logic s,
                       input logic [7:0] data, input logic dc);
    if (d == 0) begin
      b0.i_send = s; b0.i_data = data; b0.i_dc = dc;
    end else begin
      b1.i_send = s; b1.i_data = data; b1.i_dc = dc;
    end
  endtask

  task automatic push(input int d, input logic [7:0] data,
                      input logic dc, input int end_cyc);
    exp_t e;
    e.data = data; e.dc = dc; e.end_cyc = 32'(end_cyc);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic send(input int d, input logic [7:0] data,
                      input logic dc, input int lat,
                      input bit do_push, output int n0);
    @(negedge clk);
    drive(d, 1'b1, data, dc);
    n0 = cyc + 1;
    if (do_push) push(d, data, dc, n0 + lat);
    @(negedge clk);
    drive(d, 1'b0, data, dc);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((q0.size() + q1.size()) != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(q0.size() + q1.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"}, 32'(w_busy), 0);
    chk({tag, "_sent"}, 32'(w_sent), 0);
    chk({tag, "_sclk"}, 32'(w_sclk), 0);
    chk({tag, "_mosi"}, 32'(w_mosi), 0);
    chk({tag, "_dc"},   32'(w_dc),   3);
    chk({tag, "_cs"},   32'(w_cs),   3);
  endtask

  function automatic logic [8:0] hold_word(input int c);
    return c[0] ? {8'h96, 1'b1} : {8'h4B, 1'b0};
  endfunction

  logic in_burst = 1'b0;
  logic burst_cs_hi = 1'b0;
  always @(negedge clk)
    if (in_burst && b0.o_cs) burst_cs_hi = 1'b1;

  initial begin
    int n0, n1, k;
    logic [8:0] w;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk_rst("por");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 8'hA5, 1'b0, 72, 1, n0);
    drain(200);

    send(1, 8'h3C, 1'b1, 18, 1, n0);
    drain(100);

    @(negedge clk);
    k = cyc;
    n0 = k + 1;
    w = hold_word(k);
    push(0, w[8:1], w[0], n0 + 72);
`ifdef ILI_SPI_BURST_EN
    n1 = n0 + 72;
    w = hold_word(n1 - 1);
    push(0, w[8:1], w[0], n1 + 68);
`else
    n1 = n0 + 73;
    w = hold_word(n1 - 1);
    push(0, w[8:1], w[0], n1 + 72);
`endif
    forever begin
      w = hold_word(cyc);
      drive(0, 1'b1, w[8:1], w[0]);
      @(negedge clk);
      if (cyc >= n1) break;
    end
    drive(0, 1'b0, 8'h00, 1'b0);
    drain(300);

    send(0, 8'h81, 1'b1, 72, 1, n0);
    while (cyc < n0 + 29) @(negedge clk);
    drive(0, 1'b1, 8'hFF, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0);
    drain(200);
    repeat (80) @(negedge clk);
    chk("mid_send_busy", 32'(b0.o_busy), 0);

    send(0, 8'hF0, 1'b0, 72, 0, n0);
    while (cyc < n0 + 38) @(negedge clk);
    chk("abort_busy_before", 32'(b0.o_busy), 1);
    rst = 1'b0;
    #1;
    chk_rst("abort");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_idle_busy", 32'(b0.o_busy), 0);
    chk("abort_idle_cs", 32'(b0.o_cs), 1);

`ifdef ILI_SPI_BURST_EN
    send(0, 8'h2A, 1'b0, 72, 1, n0);
    in_burst = 1'b1;
    burst_cs_hi = 1'b0;
    while (cyc < n0 + 71) @(negedge clk);
    drive(0, 1'b1, 8'h00, 1'b1);
    push(0, 8'h00, 1'b1, n0 + 140);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0);
    while (cyc < n0 + 139) @(negedge clk);
    drive(0, 1'b1, 8'hEF, 1'b1);
    push(0, 8'hEF, 1'b1, n0 + 208);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0);
    while (cyc < n0 + 207) @(negedge clk);
    in_burst = 1'b0;
    chk("burst_cs_low", 32'(burst_cs_hi), 0);
    drain(100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
